// File: rtl/fsqrt_special_case.sv
// Operand classification and in-order result merge around the pipelined binary32 sqrt core.
// Optional build macro FSQRT_DAZ_EN: subnormal radicands are flushed to a signed zero locally.
module fsqrt_special_case #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             core_valid_in,
  output logic [WIDTH-1:0] core_radicand,
  input  logic             core_valid_out,
  input  logic [WIDTH-1:0] core_y,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_y,
  output logic [4:0]       out_flags,
  output logic             seq_err
);

  localparam logic [WIDTH-1:0] QNAN   = 32'h7FC0_0000;
  localparam logic [WIDTH-1:0] POSINF = 32'h7F80_0000;
  localparam logic [4:0]       NV     = 5'b1_0000;

  // Returns {special, result, flags}; result/flags are meaningful only when special.
  function automatic logic [WIDTH+5:0] classify(input logic [WIDTH-1:0] d);
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    s = d[31];
    e = d[30:23];
    f = d[22:0];
    if (e == 8'hFF && f != 23'd0)
      classify = {1'b1, QNAN, (f[22] ? 5'b0 : NV)};
    else if (e == 8'd0 && f == 23'd0)
      classify = {1'b1, d, 5'b0};
`ifdef FSQRT_DAZ_EN
    else if (e == 8'd0)
      classify = {1'b1, s, {(WIDTH-1){1'b0}}, 5'b0};
`endif
    else if (s)
      classify = {1'b1, QNAN, NV};
    else if (e == 8'hFF)
      classify = {1'b1, POSINF, 5'b0};
    else
      classify = {1'b0, d, 5'b0};
  endfunction

  logic [WIDTH+5:0] cls;
  logic             cls_spc;
  logic [WIDTH-1:0] cls_res;
  logic [4:0]       cls_flg;

  always_comb begin
    cls     = classify(in_data);
    cls_spc = cls[WIDTH+5];
    cls_res = cls[WIDTH+4:5];
    cls_flg = cls[4:0];
  end

  assign core_valid_in = in_valid & ~cls_spc;
  assign core_radicand = in_data;

  // ---- Delay line: one entry per issue slot, matched to core latency ----
  logic             dl_vld_q [LATENCY];
  logic             dl_vld_d [LATENCY];
  logic             dl_spc_q [LATENCY];
  logic             dl_spc_d [LATENCY];
  logic [WIDTH-1:0] dl_res_q [LATENCY];
  logic [WIDTH-1:0] dl_res_d [LATENCY];
  logic [4:0]       dl_flg_q [LATENCY];
  logic [4:0]       dl_flg_d [LATENCY];

  always_comb begin
    dl_vld_d[0] = in_valid;
    dl_spc_d[0] = cls_spc;
    dl_res_d[0] = cls_res;
    dl_flg_d[0] = cls_flg;
    for (int i = 1; i < LATENCY; i++) begin
      dl_vld_d[i] = dl_vld_q[i-1];
      dl_spc_d[i] = dl_spc_q[i-1];
      dl_res_d[i] = dl_res_q[i-1];
      dl_flg_d[i] = dl_flg_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) dl_vld_q[i] <= 1'b0;
    end else begin
      for (int i = 0; i < LATENCY; i++) dl_vld_q[i] <= dl_vld_d[i];
    end
  end

  // Payload carries no reset: it is qualified by dl_vld_q.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LATENCY; i++) begin
      dl_spc_q[i] <= dl_spc_d[i];
      dl_res_q[i] <= dl_res_d[i];
      dl_flg_q[i] <= dl_flg_d[i];
    end
  end

  // ---- Tap and merge: the last entry lines up with the core's valid_output ----
  logic             tap_vld;
  logic             tap_spc;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_y_q, out_y_d;
  logic [4:0]       out_flags_q, out_flags_d;
  logic             seq_err_q, seq_err_d;

  always_comb begin
    tap_vld     = dl_vld_q[LATENCY-1];
    tap_spc     = dl_spc_q[LATENCY-1];
    out_valid_d = tap_vld;
    out_y_d     = out_y_q;
    out_flags_d = out_flags_q;
    seq_err_d   = seq_err_q;
    if (tap_vld && tap_spc) begin
      out_y_d     = dl_res_q[LATENCY-1];
      out_flags_d = dl_flg_q[LATENCY-1];
    end else if (tap_vld) begin
      out_y_d     = core_y;
      out_flags_d = 5'b0;
      if (!core_valid_out) seq_err_d = 1'b1;
    end
    // A core result with no core-path slot waiting for it is dropped.
    if (core_valid_out && (!tap_vld || tap_spc)) seq_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_flags_q <= 5'b0;
      seq_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_flags_q <= out_flags_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_flags = out_flags_q;
  assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_fsqrt_special_case.sv
// Directed bench for fsqrt_special_case with a table-driven behavioural sqrt core of adjustable latency.
module tb_fsqrt_special_case;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        core_valid_in;
  logic [31:0] core_radicand;
  logic        core_valid_out;
  logic [31:0] core_y;
  logic        out_valid;
  logic [31:0] out_y;
  logic [4:0]  out_flags;
  logic        seq_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  fsqrt_special_case #(.WIDTH(32), .LATENCY(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data),
    .core_valid_in(core_valid_in), .core_radicand(core_radicand),
    .core_valid_out(core_valid_out), .core_y(core_y),
    .out_valid(out_valid), .out_y(out_y), .out_flags(out_flags),
    .seq_err(seq_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural core: known radicands only, output tap selectable for misalignment.
  function automatic logic [31:0] sqrt_model(input logic [31:0] x);
    case (x)
      32'h4080_0000: sqrt_model = 32'h4000_0000;
      32'h4000_0000: sqrt_model = 32'h3FB5_04F3;
      32'h3F80_0000: sqrt_model = 32'h3F80_0000;
      32'h4110_0000: sqrt_model = 32'h4040_0000;
      32'h0000_0001: sqrt_model = 32'h1A35_04F3;
      default:       sqrt_model = 32'h0000_0000;
    endcase
  endfunction

  logic        cm_v [8];
  logic [31:0] cm_y [8];
  logic [2:0]  cm_tap = 3'd5;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) cm_v[i] <= 1'b0;
    end else begin
      cm_v[0] <= core_valid_in;
      cm_y[0] <= sqrt_model(core_radicand);
      for (int i = 1; i < 8; i++) begin
        cm_v[i] <= cm_v[i-1];
        cm_y[i] <= cm_y[i-1];
      end
    end
  end

  assign core_valid_out = cm_v[cm_tap];
  assign core_y         = cm_y[cm_tap];

  logic [31:0] q_y [$];
  logic [4:0]  q_f [$];
  int          q_c [$];

  always @(negedge clk) begin
    if (out_valid) begin
      q_y.push_back(out_y);
      q_f.push_back(out_flags);
      q_c.push_back(cyc);
    end
  end

  task automatic clear_q();
    q_y.delete(); q_f.delete(); q_c.delete();
  endtask

  task automatic issue(input logic [31:0] d, output int c);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    c = cyc;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 32'h0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, out_y, out_flags, seq_err} !== 39'd0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b y=%h f=%h e=%b exp all zero", out_valid, out_y, out_flags, seq_err);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || core_valid_in !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got out_valid=%b core_valid_in=%b exp 0 0", out_valid, core_valid_in);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] din [4] = '{32'h4080_0000, 32'h4000_0000, 32'h3F80_0000, 32'h4110_0000};
    logic [31:0] ey  [4] = '{32'h4000_0000, 32'h3FB5_04F3, 32'h3F80_0000, 32'h4040_0000};
    int ic [4];
    clear_q();
    for (int i = 0; i < 4; i++) begin
      issue(din[i], ic[i]);
      #1;
      checks++;
      if (core_valid_in !== 1'b1) begin
        failures++;
        $display("FAIL b2b_core_valid_in[%0d] got %b exp 1", i, core_valid_in);
      end
    end
    idle(10);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= q_y.size()) begin
        failures++;
        $display("FAIL b2b_missing[%0d] got %0d results exp 4", i, q_y.size());
      end else if (q_y[i] !== ey[i] || q_f[i] !== 5'h00 || q_c[i] !== ic[i] + 7) begin
        failures++;
        $display("FAIL b2b_result[%0d] got y=%h f=%h cyc=%0d exp y=%h f=00 cyc=%0d",
                 i, q_y[i], q_f[i], q_c[i], ey[i], ic[i] + 7);
      end
    end
    checks++;
    if (seq_err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_seq_err got %b exp 0", seq_err);
    end
  endtask

  task automatic test_special_mix();
    logic [31:0] din [5] = '{32'h7F80_0001, 32'hBF80_0000, 32'h8000_0000, 32'h7F80_0000, 32'h7FC0_0000};
    logic [31:0] ey  [5] = '{32'h7FC0_0000, 32'h7FC0_0000, 32'h8000_0000, 32'h7F80_0000, 32'h7FC0_0000};
    logic [4:0]  ef  [5] = '{5'h10, 5'h10, 5'h00, 5'h00, 5'h00};
    int ic [5];
    clear_q();
    for (int i = 0; i < 5; i++) begin
      issue(din[i], ic[i]);
      #1;
      checks++;
      if (core_valid_in !== 1'b0) begin
        failures++;
        $display("FAIL spc_core_valid_in[%0d] got %b exp 0", i, core_valid_in);
      end
    end
    idle(10);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= q_y.size()) begin
        failures++;
        $display("FAIL spc_missing[%0d] got %0d results exp 5", i, q_y.size());
      end else if (q_y[i] !== ey[i] || q_f[i] !== ef[i] || q_c[i] !== ic[i] + 7) begin
        failures++;
        $display("FAIL spc_result[%0d] got y=%h f=%h cyc=%0d exp y=%h f=%h cyc=%0d",
                 i, q_y[i], q_f[i], q_c[i], ey[i], ef[i], ic[i] + 7);
      end
    end
  endtask

  task automatic test_interleave();
    logic [31:0] din [3] = '{32'h4080_0000, 32'hC000_0000, 32'h4110_0000};
    logic [31:0] ey  [3] = '{32'h4000_0000, 32'h7FC0_0000, 32'h4040_0000};
    logic [4:0]  ef  [3] = '{5'h00, 5'h10, 5'h00};
    logic        ecv [3] = '{1'b1, 1'b0, 1'b1};
    int ic [3];
    clear_q();
    for (int i = 0; i < 3; i++) begin
      issue(din[i], ic[i]);
      #1;
      checks++;
      if (core_valid_in !== ecv[i]) begin
        failures++;
        $display("FAIL ilv_core_valid_in[%0d] got %b exp %b", i, core_valid_in, ecv[i]);
      end
    end
    idle(10);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= q_y.size()) begin
        failures++;
        $display("FAIL ilv_missing[%0d] got %0d results exp 3", i, q_y.size());
      end else if (q_y[i] !== ey[i] || q_f[i] !== ef[i] || q_c[i] !== ic[i] + 7) begin
        failures++;
        $display("FAIL ilv_result[%0d] got y=%h f=%h cyc=%0d exp y=%h f=%h cyc=%0d",
                 i, q_y[i], q_f[i], q_c[i], ey[i], ef[i], ic[i] + 7);
      end
    end
  endtask

  task automatic test_subnormal();
    logic [31:0] din [2] = '{32'h0000_0001, 32'h8000_0001};
`ifdef FSQRT_DAZ_EN
    logic [31:0] ey  [2] = '{32'h0000_0000, 32'h8000_0000};
    logic [4:0]  ef  [2] = '{5'h00, 5'h00};
    logic        ecv [2] = '{1'b0, 1'b0};
`else
    logic [31:0] ey  [2] = '{32'h1A35_04F3, 32'h7FC0_0000};
    logic [4:0]  ef  [2] = '{5'h00, 5'h10};
    logic        ecv [2] = '{1'b1, 1'b0};
`endif
    int ic [2];
    clear_q();
    for (int i = 0; i < 2; i++) begin
      issue(din[i], ic[i]);
      #1;
      checks++;
      if (core_valid_in !== ecv[i]) begin
        failures++;
        $display("FAIL sub_core_valid_in[%0d] got %b exp %b", i, core_valid_in, ecv[i]);
      end
    end
    idle(10);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= q_y.size()) begin
        failures++;
        $display("FAIL sub_missing[%0d] got %0d results exp 2", i, q_y.size());
      end else if (q_y[i] !== ey[i] || q_f[i] !== ef[i] || q_c[i] !== ic[i] + 7) begin
        failures++;
        $display("FAIL sub_result[%0d] got y=%h f=%h cyc=%0d exp y=%h f=%h cyc=%0d",
                 i, q_y[i], q_f[i], q_c[i], ey[i], ef[i], ic[i] + 7);
      end
    end
  endtask

  task automatic test_misalign();
    int c0;
    cm_tap = 3'd4;
    issue(32'h4080_0000, c0);
    #1;
    checks++;
    if (seq_err !== 1'b0) begin
      failures++;
      $display("FAIL mis_seq_err_early got %b exp 0", seq_err);
    end
    idle(10);
    checks++;
    if (seq_err !== 1'b1) begin
      failures++;
      $display("FAIL mis_seq_err_set got %b exp 1", seq_err);
    end
    cm_tap = 3'd5;
    issue(32'h3F80_0000, c0);
    idle(10);
    checks++;
    if (seq_err !== 1'b1) begin
      failures++;
      $display("FAIL mis_seq_err_sticky got %b exp 1", seq_err);
    end
  endtask

  task automatic test_reset_in_flight();
    int c0;
    for (int i = 0; i < 3; i++) issue(32'h4000_0000, c0);
    idle(1);
    clear_q();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_y, out_flags, seq_err} !== 39'd0) begin
      failures++;
      $display("FAIL rst_mid_outputs got v=%b y=%h f=%h e=%b exp all zero", out_valid, out_y, out_flags, seq_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (q_y.size() != 0 || seq_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_flush got results=%0d seq_err=%b exp 0 0", q_y.size(), seq_err);
    end
    issue(32'h4110_0000, c0);
    idle(10);
    checks++;
    if (q_y.size() != 1) begin
      failures++;
      $display("FAIL rst_after_count got %0d results exp 1", q_y.size());
    end else if (q_y[0] !== 32'h4040_0000 || q_f[0] !== 5'h00 || q_c[0] !== c0 + 7) begin
      failures++;
      $display("FAIL rst_after_result got y=%h f=%h cyc=%0d exp y=40400000 f=00 cyc=%0d",
               q_y[0], q_f[0], q_c[0], c0 + 7);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_special_mix();
    test_interleave();
    test_subnormal();
    test_misalign();
    test_reset_in_flight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
